// File: rtl/bus_master.sv
// Single-master initiator for the shared address/data/control bus.
// Each request becomes one SETUP / ACCESS / HOLD bus cycle.
module bus_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEV_BITS    = 2,
  parameter int NUM_DEV     = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [NUM_DEV-1:0] bus_ce,
  inout  wire  [DATA_W-1:0] bus_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DEV_BITS-1:0] dev_idx;
  logic                dev_bad;
  logic [NUM_DEV-1:0]  ce_dec;
  logic                drive;

  assign dev_idx = addr_q[ADDR_W-1 -: DEV_BITS];
  assign dev_bad = int'(dev_idx) >= NUM_DEV;

  always_comb begin
    ce_dec = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_idx == DEV_BITS'(i)) ce_dec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          state_d = S_HOLD;
          err_d   = dev_bad;
          // an unmapped device never answers, so return zero
          if (rw_q) rdata_d = dev_bad ? '0 : bus_data;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_HOLD);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign bus_addr  = addr_q;
  assign bus_rw    = (state_q == S_IDLE) ? 1'b1 : rw_q;
  assign bus_ce    = (state_q == S_ACCESS) ? ce_dec : '0;

  assign drive    = (state_q != S_IDLE) && !rw_q;
  assign bus_data = drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Initiator for the lab's shared address/data/control bus: turns single-word read/write requests from a sequencer into timed bus cycles.
- Drives address, rw and one-hot chip enables; drives data on writes and samples it on reads.
- Peripherals (input switches, output LEDs, etc.) respond on the bus; this block is the only bus master.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
DEV_BITS, 2, number of top address bits decoded into a chip-enable index
NUM_DEV, 4, number of chip enables implemented (≤ 2**DEV_BITS)
WAIT_CYCLES, 2, extra cycles ce stays asserted beyond the first (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (IDLE only)
req_rw  input  1  1 = read, 0 = write
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle completion pulse (reads and writes)
rsp_rdata  output  DATA_W  read data, valid with rsp_valid
rsp_err  output  1  device index ≥ NUM_DEV, valid with rsp_valid
busy  output  1  high in any state other than IDLE
bus_addr  output  ADDR_W  bus address
bus_rw  output  1  bus control: 1 = read, 0 = write
bus_ce  output  NUM_DEV  one-hot chip enables, active high
bus_data  inout  DATA_W  shared data bus, high-Z unless writing

Behaviour:
- Single clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_addr=0, bus_rw=1, bus_ce=0, bus_data=Z, state=IDLE, wait counter=0.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE
  - req_ready=1.
  - When req_valid&&req_ready at an edge, capture rw, addr and wdata, then go to SETUP.
  - bus_rw=1 and bus_data=Z in IDLE.
- SETUP (1 cycle)
  - bus_addr and bus_rw take the captured values; bus_ce=0.
  - On a write, bus_data drives wdata.
  - Next state: ACCESS, with counter cleared.
- ACCESS (WAIT_CYCLES+1 cycles)
  - bus_ce[idx]=1, where idx=addr[ADDR_W-1 -: DEV_BITS].
  - If idx ≥ NUM_DEV, no ce bit is asserted and rsp_err is set.
  - The counter increments each cycle.
  - On the edge leaving ACCESS (counter==WAIT_CYCLES), a read registers bus_data into rsp_rdata. If rsp_err is set, rsp_rdata is forced to 0.
- HOLD (1 cycle)
  - bus_ce=0; bus_addr and bus_rw are held.
  - Write data stays driven for hold time.
  - rsp_valid=1 for this cycle only.
  - Next state: IDLE, where bus_rw returns to 1 and bus_data goes to Z.
- Latency:
  - rsp_valid rises at the (WAIT_CYCLES+2)th rising edge after the accepting edge.
  - The next request can be accepted at edge WAIT_CYCLES+4 at the earliest.
  - Throughput: one transaction per WAIT_CYCLES+4 cycles.
- Request inputs are ignored outside IDLE. A held req_valid is accepted exactly once per IDLE visit.
- rsp_rdata holds its value until the next read completes. Writes leave rsp_rdata unchanged.
- bus_data is driven only in SETUP/ACCESS/HOLD of a write. It is never driven during a read or in IDLE, so there is no contention with responders.
- Reset mid-transaction:
  - At the reset edge the block returns to IDLE with all reset values: ce=0 and data released.
  - No rsp_valid is issued for the aborted request.
- Reset has priority over an acceptance in the same cycle.

Test Plan:
- Write, WAIT_CYCLES=2, addr=0x41, wdata=0xA5, accepted at edge 0:
  - edge 1: bus_addr=0x41, bus_rw=0, bus_data=0xA5, bus_ce=0.
  - edges 2–4: bus_ce=4'b0010.
  - after edge 4: rsp_valid pulse with bus_ce=0.
  - after edge 5: bus_data=Z.
- Read, addr=0x00, responder model drives ~in_sw with in_sw=0x3C while ce[0]&&rw:
  - rsp_rdata=0xC3 with rsp_valid after edge 4.
  - bus_data is never driven by the master.
- Back-to-back, req_valid held high with two requests:
  - second acceptance occurs exactly at edge 6.
  - no duplicate transaction.
  - busy is low only for the one IDLE cycle.
- Reset asserted during the second ACCESS cycle of a write:
  - next edge: bus_ce=0, bus_data=Z, bus_rw=1, req_ready=1.
  - no rsp_valid is seen.
- NUM_DEV=3, read addr=0xC0:
  - bus_ce stays 0 throughout.
  - rsp_err=1, rsp_rdata=0x00.
  - timing is identical to a normal read.
- WAIT_CYCLES=0:
  - ce is asserted for exactly 1 cycle.
  - rsp_valid follows at the 2nd edge after acceptance.
